// File: rtl/mode7_param_seq.sv
// mode7_param_seq: per-frame parameter sequencer for the Mode7 affine stage.
// Buttons are synchronised and accumulated into sticky pending flags during a
// frame; new angle/offset/scale values are committed only after a vsync rising
// edge, so the parameters never change mid-frame.
// Optional feature: define MODE7_AUTOROTATE_EN to add the auto_rot input, which
// advances the angle at each commit when no rotate button is pending.
module mode7_param_seq #(
    parameter int unsigned ANGLE_STEPS = 360,
    parameter int unsigned ANGLE_STEP  = 1,
    parameter logic [15:0] OFF_STEP    = 16'd1,
    parameter logic [23:0] SCALE_INIT  = 24'h000100,
    parameter logic [23:0] SCALE_STEP  = 24'h000010,
    parameter logic [23:0] SCALE_MIN   = 24'h000040,
    parameter logic [23:0] SCALE_MAX   = 24'h00FF00,
    parameter int unsigned FRAME_DIV   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rot_cw,
    input  logic        btn_rot_ccw,
    input  logic        btn_zoom_in,
    input  logic        btn_zoom_out,
`ifdef MODE7_AUTOROTATE_EN
    input  logic        auto_rot,
`endif
    output logic [9:0]  angle,
    output logic [15:0] offsetx,
    output logic [15:0] offsety,
    output logic [23:0] scale,
    output logic        upd
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, COMMIT = 2'd2} state_t;

    localparam logic [9:0] STEPS_A  = 10'(ANGLE_STEPS);
    localparam logic [9:0] STEP_A   = 10'(ANGLE_STEP);
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    // Flag bit order: 0 up, 1 down, 2 left, 3 right, 4 cw, 5 ccw, 6 zoom in, 7 zoom out
    logic [7:0]  btn_raw_s;
    logic [7:0]  btn_meta_r;
    logic [7:0]  btn_sync_r;
    logic [7:0]  pend_r;
    logic        vsync_q_r;
    logic        vsync_d_r;
    logic        vsync_rise_s;
    logic [7:0]  frame_cnt_r;
    state_t      state_r;
    state_t      state_nxt_s;

    logic [9:0]  ang_sum_s;
    logic [9:0]  ang_inc_s;
    logic [9:0]  ang_dec_s;
    logic [23:0] sc_inc_s;
    logic [23:0] sc_dec_s;
    logic        auto_inc_s;
    logic [9:0]  angle_nxt_s;
    logic [15:0] offx_nxt_s;
    logic [15:0] offy_nxt_s;
    logic [23:0] scale_nxt_s;

    logic [9:0]  angle_sh_r;
    logic [15:0] offx_sh_r;
    logic [15:0] offy_sh_r;
    logic [23:0] scale_sh_r;

    assign btn_raw_s = {btn_zoom_out, btn_zoom_in, btn_rot_ccw, btn_rot_cw,
                        btn_right, btn_left, btn_down, btn_up};

    // vsync_d starts high so a vsync already high at reset release is not an edge
    assign vsync_rise_s = vsync_q_r & ~vsync_d_r;

    // Two-flop synchroniser for buttons plus vsync sample/delay for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_r <= 8'h00;
            btn_sync_r <= 8'h00;
            vsync_q_r  <= 1'b1;
            vsync_d_r  <= 1'b1;
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            vsync_q_r  <= vsync;
            vsync_d_r  <= vsync_q_r;
        end
    end

    // Sticky pending flags; CALC takes the snapshot and restarts from this cycle's presses
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= 8'h00;
        end else if (state_r == CALC) begin
            pend_r <= btn_sync_r;
        end else begin
            pend_r <= pend_r | btn_sync_r;
        end
    end

    // Frame divider: counts vsync edges seen in IDLE only
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 8'd0;
        end else if ((state_r == IDLE) && vsync_rise_s) begin
            frame_cnt_r <= (frame_cnt_r == DIV_LAST) ? 8'd0 : frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: edges arriving in CALC/COMMIT are ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (vsync_rise_s && (frame_cnt_r == DIV_LAST)) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC:    state_nxt_s = COMMIT;
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Angle wraps by compare-and-correct; scale saturates without overflowing 24 bits
    assign ang_sum_s = angle + STEP_A;
    assign ang_inc_s = (ang_sum_s >= STEPS_A) ? (ang_sum_s - STEPS_A) : ang_sum_s;
    assign ang_dec_s = (angle < STEP_A) ? (angle + (STEPS_A - STEP_A)) : (angle - STEP_A);
    assign sc_inc_s  = (scale > (SCALE_MAX - SCALE_STEP)) ? SCALE_MAX : (scale + SCALE_STEP);
    assign sc_dec_s  = (scale < (SCALE_MIN + SCALE_STEP)) ? SCALE_MIN : (scale - SCALE_STEP);

`ifdef MODE7_AUTOROTATE_EN
    assign auto_inc_s = auto_rot & ~pend_r[4] & ~pend_r[5];
`else
    assign auto_inc_s = 1'b0;
`endif

    // Next parameter values from the pending snapshot; opposite pairs cancel
    always_comb begin
        angle_nxt_s = angle;
        offx_nxt_s  = offsetx;
        offy_nxt_s  = offsety;
        scale_nxt_s = scale;
        if ((pend_r[4] && !pend_r[5]) || auto_inc_s) begin
            angle_nxt_s = ang_inc_s;
        end else if (pend_r[5] && !pend_r[4]) begin
            angle_nxt_s = ang_dec_s;
        end else begin
            angle_nxt_s = angle;
        end
        if (pend_r[3] && !pend_r[2]) begin
            offx_nxt_s = offsetx + OFF_STEP;
        end else if (pend_r[2] && !pend_r[3]) begin
            offx_nxt_s = offsetx - OFF_STEP;
        end else begin
            offx_nxt_s = offsetx;
        end
        if (pend_r[1] && !pend_r[0]) begin
            offy_nxt_s = offsety + OFF_STEP;
        end else if (pend_r[0] && !pend_r[1]) begin
            offy_nxt_s = offsety - OFF_STEP;
        end else begin
            offy_nxt_s = offsety;
        end
        if (pend_r[6] && !pend_r[7]) begin
            scale_nxt_s = sc_inc_s;
        end else if (pend_r[7] && !pend_r[6]) begin
            scale_nxt_s = sc_dec_s;
        end else begin
            scale_nxt_s = scale;
        end
    end

    // Shadow registers capture the computed values in CALC
    always_ff @(posedge clk) begin
        if (reset) begin
            angle_sh_r <= 10'd0;
            offx_sh_r  <= 16'd0;
            offy_sh_r  <= 16'd0;
            scale_sh_r <= SCALE_INIT;
        end else if (state_r == CALC) begin
            angle_sh_r <= angle_nxt_s;
            offx_sh_r  <= offx_nxt_s;
            offy_sh_r  <= offy_nxt_s;
            scale_sh_r <= scale_nxt_s;
        end else begin
            angle_sh_r <= angle_sh_r;
            offx_sh_r  <= offx_sh_r;
            offy_sh_r  <= offy_sh_r;
            scale_sh_r <= scale_sh_r;
        end
    end

    // Outputs load from shadow on leaving COMMIT, with upd marking that cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            angle   <= 10'd0;
            offsetx <= 16'd0;
            offsety <= 16'd0;
            scale   <= SCALE_INIT;
            upd     <= 1'b0;
        end else if (state_r == COMMIT) begin
            angle   <= angle_sh_r;
            offsetx <= offx_sh_r;
            offsety <= offy_sh_r;
            scale   <= scale_sh_r;
            upd     <= 1'b1;
        end else begin
            angle   <= angle;
            offsetx <= offsetx;
            offsety <= offsety;
            scale   <= scale;
            upd     <= 1'b0;
        end
    end

endmodule
